// File: rtl/mem_if_pkg.sv
// Shared memory request/response definitions: command codes, responder states
// and the fill pattern returned for out-of-range reads.
package mem_if_pkg;

    localparam logic [31:0] CMD_NO    = 32'd0;
    localparam logic [31:0] CMD_READ  = 32'd1;
    localparam logic [31:0] CMD_WRITE = 32'd2;

    localparam logic [31:0] OOR_READ_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        RS_IDLE    = 3'd0,
        RS_BUSY    = 3'd1,
        RS_RESP    = 3'd2,
        RS_RELEASE = 3'd3
    } resp_state_t;

endpackage

// File: rtl/mem_responder_array.sv
// 1R1W synchronous word array; read data is registered, contents are never reset.
module mem_responder_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: fixed-latency read/write service with one-cycle completion.
// Optional bounds checking is enabled with `define MEM_RESPONDER_BOUNDS_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for READ/WRITE; accepts and latches the request
// BUSY    | counting down the command latency
// RESP    | completion cycle; write is committed at the end of it
// RELEASE | waiting for the command to drop to NO before re-arming
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2    = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] request_addr,
    input  logic [31:0] request_data,
    input  logic [31:0] request_command,
    output logic        response_complete,
    output logic [31:0] response_data,
    output logic [2:0]  resp_state,
    output logic        resp_err
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);

    resp_state_t           state;
    logic [CNT_W-1:0]      cnt;
    logic                  is_write;
    logic                  oor;
    logic                  oor_in;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [31:0]           data_q;
    logic [DEPTH_LOG2-1:0] raddr;
    logic [31:0]           rd_data;
    logic                  we;
    logic                  accept;

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    assign oor_in = |request_addr[31:DEPTH_LOG2];
`else
    logic unused_upper_addr;
    assign unused_upper_addr = ^request_addr[31:DEPTH_LOG2];
    assign oor_in = 1'b0;
`endif

    assign accept = (state == RS_IDLE) &&
                    ((request_command == CMD_READ) || (request_command == CMD_WRITE));

    // Read the incoming address while idle so even a 1-cycle read has data in time.
    assign raddr = (state == RS_IDLE) ? request_addr[DEPTH_LOG2-1:0] : addr_q;
    assign we    = (state == RS_RESP) && is_write && !oor && !rst;

    mem_responder_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .waddr(addr_q),
        .wdata(data_q),
        .raddr(raddr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= RS_IDLE;
            cnt               <= '0;
            is_write          <= 1'b0;
            oor               <= 1'b0;
            addr_q            <= '0;
            data_q            <= '0;
            response_complete <= 1'b0;
            response_data     <= '0;
            resp_err          <= 1'b0;
        end else begin
            response_complete <= 1'b0;
            resp_err          <= 1'b0;
            case (state)
                RS_IDLE: begin
                    if (accept) begin
                        is_write <= (request_command == CMD_WRITE);
                        addr_q   <= request_addr[DEPTH_LOG2-1:0];
                        data_q   <= request_data;
                        oor      <= oor_in;
                        cnt      <= (request_command == CMD_WRITE) ? WRITE_LOAD : READ_LOAD;
                        state    <= RS_BUSY;
                    end
                end
                RS_BUSY: begin
                    if (cnt == '0) begin
                        state             <= RS_RESP;
                        response_complete <= 1'b1;
                        resp_err          <= oor;
                        if (!is_write) begin
                            response_data <= oor ? OOR_READ_DATA : rd_data;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RS_RESP: state <= RS_RELEASE;
                RS_RELEASE: begin
                    if (request_command == CMD_NO) begin
                        state <= RS_IDLE;
                    end
                end
                default: state <= RS_IDLE;
            endcase
        end
    end

    assign resp_state = state;

endmodule
